// File: rtl/restoring_divider_4bit.sv
// Sequential 4-bit unsigned restoring divider: one quotient bit per clock,
// four iterations per operation, with a divide-by-zero short path.
module restoring_divider_4bit (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [3:0] dividend,
  input  logic [3:0] divisor,
  output logic [3:0] quotient,
  output logic [3:0] remainder,
  output logic       busy,
  output logic       done,
  output logic       div_zero
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state_r;
  state_t      state_s;
  logic [3:0]  d_r;
  logic [3:0]  v_r;
  // Partial remainder stays below the divisor, so its fifth bit is always
  // zero and only the low four bits are stored.
  logic [3:0]  r_r;
  // Only three quotient bits are kept; the fourth joins them on the final load.
  logic [2:0]  q_r;
  logic [1:0]  cnt_r;
  logic [3:0]  quotient_r;
  logic [3:0]  remainder_r;
  logic        div_zero_r;
  logic [4:0]  trial_s;
  logic [3:0]  r_next_s;
  logic        q_bit_s;

  // Trial subtraction and restore decision for the current iteration.
  always_comb begin
    trial_s  = {r_r, d_r[3]} - {1'b0, v_r};
    r_next_s = 4'd0;
    q_bit_s  = 1'b0;
    if (!trial_s[4]) begin
      r_next_s = trial_s[3:0];
      q_bit_s  = 1'b1;
    end else begin
      r_next_s = {r_r[2:0], d_r[3]};
      q_bit_s  = 1'b0;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_s = (divisor == 4'd0) ? DONE : CALC;
        end else begin
          state_s = IDLE;
        end
      end
      CALC: begin
        if (cnt_r == 2'd3) begin
          state_s = DONE;
        end else begin
          state_s = CALC;
        end
      end
      DONE:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // Working registers and result registers; results load only on DONE entry.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      d_r         <= 4'd0;
      v_r         <= 4'd0;
      r_r         <= 4'd0;
      q_r         <= 3'd0;
      cnt_r       <= 2'd0;
      quotient_r  <= 4'd0;
      remainder_r <= 4'd0;
      div_zero_r  <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (start) begin
            d_r   <= dividend;
            v_r   <= divisor;
            r_r   <= 4'd0;
            q_r   <= 3'd0;
            cnt_r <= 2'd0;
            if (divisor == 4'd0) begin
              quotient_r  <= 4'hF;
              remainder_r <= dividend;
              div_zero_r  <= 1'b1;
            end
          end
        end
        CALC: begin
          r_r   <= r_next_s;
          q_r   <= {q_r[1:0], q_bit_s};
          d_r   <= {d_r[2:0], 1'b0};
          cnt_r <= cnt_r + 2'd1;
          if (cnt_r == 2'd3) begin
            quotient_r  <= {q_r, q_bit_s};
            remainder_r <= r_next_s;
            div_zero_r  <= 1'b0;
          end
        end
        default: begin
          d_r <= d_r;
        end
      endcase
    end
  end

  // Output decode from registered state only.
  always_comb begin
    busy      = (state_r == CALC);
    done      = (state_r == DONE);
    quotient  = quotient_r;
    remainder = remainder_r;
    div_zero  = div_zero_r;
  end

endmodule

// File: tb/tb_restoring_divider_4bit.sv
// Scoreboard bench for restoring_divider_4bit: stimulus pushes expected
// results, a negedge monitor pops and compares on every done pulse.
module tb_restoring_divider_4bit;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [3:0] dividend;
  logic [3:0] divisor;
  logic [3:0] quotient;
  logic [3:0] remainder;
  logic       busy;
  logic       done;
  logic       div_zero;

  typedef struct {
    logic [3:0] q;
    logic [3:0] r;
    logic       dz;
    int         cyc;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   issued = 0;
  int   done_count = 0;

  restoring_divider_4bit dut (
    .clk(clk), .rst_n(rst_n), .start(start), .dividend(dividend),
    .divisor(divisor), .quotient(quotient), .remainder(remainder),
    .busy(busy), .done(done), .div_zero(div_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && done) begin
      done_count++;
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done with empty scoreboard at cycle %0d", cyc);
      end else begin
        e = sb.pop_front();
        chk("quotient", {4'd0, quotient}, {4'd0, e.q});
        chk("remainder", {4'd0, remainder}, {4'd0, e.r});
        chk("div_zero", {7'd0, div_zero}, {7'd0, e.dz});
        chk("done_cycle", 8'(cyc), 8'(e.cyc));
      end
    end
  end

  task automatic op(input logic [3:0] a, input logic [3:0] b,
                    input logic [3:0] eq, input logic [3:0] er, input logic edz);
    exp_t e;
    int   ee;
    @(negedge clk);
    start = 1'b1; dividend = a; divisor = b;
    ee = cyc + 1;
    e.q = eq; e.r = er; e.dz = edz;
    e.cyc = ee + ((b == 4'd0) ? 0 : 4);
    sb.push_back(e);
    issued++;
    @(negedge clk);
    start = 1'b0;
    if (b == 4'd0) begin
      chk("busy_dz", {7'd0, busy}, 8'd0);
      @(negedge clk);
      chk("busy_dz_after", {7'd0, busy}, 8'd0);
    end else begin
      for (int i = 0; i < 4; i++) begin
        chk("busy_calc", {7'd0, busy}, 8'd1);
        @(negedge clk);
      end
      chk("busy_end", {7'd0, busy}, 8'd0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int ee;
    exp_t e;
    rst_n = 1'b0; start = 1'b0; dividend = 4'd0; divisor = 4'd0;
    repeat (3) @(negedge clk);
    chk("rst_quotient", {4'd0, quotient}, 8'd0);
    chk("rst_remainder", {4'd0, remainder}, 8'd0);
    chk("rst_flags", {5'd0, busy, done, div_zero}, 8'd0);
    rst_n = 1'b1;

    op(4'd13, 4'd3, 4'd4, 4'd1, 1'b0);
    op(4'd15, 4'd1, 4'd15, 4'd0, 1'b0);
    op(4'd7, 4'd9, 4'd0, 4'd7, 1'b0);
    op(4'd15, 4'd15, 4'd1, 4'd0, 1'b0);
    op(4'd0, 4'd5, 4'd0, 4'd0, 1'b0);
    op(4'd9, 4'd0, 4'hF, 4'd9, 1'b1);
    op(4'd8, 4'd2, 4'd4, 4'd0, 1'b0);

    // 12/5 with a 3/1 request asserted during CALC that must be dropped.
    @(negedge clk);
    start = 1'b1; dividend = 4'd12; divisor = 4'd5;
    ee = cyc + 1;
    e.q = 4'd2; e.r = 4'd2; e.dz = 1'b0; e.cyc = ee + 4;
    sb.push_back(e);
    issued++;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    start = 1'b1; dividend = 4'd3; divisor = 4'd1;
    chk("hold_quotient", {4'd0, quotient}, 8'd4);
    chk("hold_remainder", {4'd0, remainder}, 8'd0);
    repeat (2) @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk("idle_after_drop", {6'd0, busy, done}, 8'd0);

    // 14/3 aborted by reset at E+2.
    @(negedge clk);
    start = 1'b1; dividend = 4'd14; divisor = 4'd3;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("abort_quotient", {4'd0, quotient}, 8'd0);
    chk("abort_remainder", {4'd0, remainder}, 8'd0);
    chk("abort_flags", {5'd0, busy, done, div_zero}, 8'd0);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    op(4'd6, 4'd4, 4'd1, 4'd2, 1'b0);

    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        if (b == 0) begin
          op(4'(a), 4'd0, 4'hF, 4'(a), 1'b1);
        end else begin
          op(4'(a), 4'(b), 4'(a / b), 4'(a % b), 1'b0);
        end
      end
    end

    repeat (6) @(negedge clk);
    chk("scoreboard_empty", 8'(sb.size()), 8'd0);
    checks++;
    if (done_count != issued) begin
      errors++;
      $display("FAIL done_count: got %0d expected %0d", done_count, issued);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
